vx_warp_ctl_handler: RTL and testbench

VX_WARP_CTL_HANDLER -- requirements
Module: VX_warp_ctl_handler

---
 rtl/vx_warp_ctl_handler.sv | 196 +++++++++++++++++++
 tb/tb_vx_warp_ctl_handler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_warp_ctl_handler.sv
// Warp control handler: TMC, WSPAWN, barrier and SPLIT requests with registered outputs.
// Barrier logic (storage, stalls and release pulses) exists only when VX_WCTL_BARRIER_EN is defined.
module vx_warp_ctl_handler #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int PC_W         = 32,
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid,
  input  logic [NW_W-1:0]                  wid,
  input  logic                             tmc_valid,
  input  logic [NUM_THREADS-1:0]           tmc_tmask,
  input  logic                             wspawn_valid,
  input  logic [NUM_WARPS-1:0]             wspawn_wmask,
  input  logic [PC_W-1:0]                  wspawn_pc,
  input  logic                             bar_valid,
  input  logic [NB_W-1:0]                  bar_id,
  input  logic [NW_W-1:0]                  bar_size_m1,
  input  logic                             split_valid,
  input  logic                             split_diverged,
  input  logic [NUM_THREADS-1:0]           split_then_tmask,
  input  logic [NUM_THREADS-1:0]           split_else_tmask,
  input  logic [PC_W-1:0]                  split_pc,
  output logic [NUM_WARPS-1:0]             active_warps,
  output logic [NUM_WARPS-1:0]             stalled_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic                             spawn_valid,
  output logic [NUM_WARPS-1:0]             spawn_wmask,
  output logic [PC_W-1:0]                  spawn_pc,
  output logic                             bar_release,
  output logic [NB_W-1:0]                  bar_release_id,
  output logic                             ipdom_push,
  output logic [NW_W-1:0]                  ipdom_wid,
  output logic [NUM_THREADS-1:0]           ipdom_tmask,
  output logic [PC_W-1:0]                  ipdom_pc
);

  logic [NUM_WARPS-1:0] wid_oh;
  logic                 tmc_fire;
  logic                 wspawn_fire;
  logic                 split_fire;
  logic [NUM_WARPS-1:0] spawn_mask;

  assign wid_oh      = NUM_WARPS'(1) << wid;
  assign tmc_fire    = valid & tmc_valid;
  assign wspawn_fire = valid & wspawn_valid;
  assign split_fire  = valid & split_valid & split_diverged;
  assign spawn_mask  = wspawn_fire ? (wspawn_wmask & ~wid_oh) : '0;

  // Per-warp state; TMC is applied last so it overrides a same-cycle SPLIT on tmask.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [NUM_THREADS-1:0] tmask_q, tmask_d;
    logic                   active_q, active_d;
    logic                   sel;

    assign sel = (wid == NW_W'(w));

    always_comb begin
      tmask_d  = tmask_q;
      active_d = active_q;
      if (spawn_mask[w]) begin
        active_d = 1'b1;
        tmask_d  = NUM_THREADS'(1);
      end
      if (sel && split_fire) begin
        tmask_d = split_then_tmask;
      end
      if (sel && tmc_fire) begin
        tmask_d  = tmc_tmask;
        active_d = |tmc_tmask;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        tmask_q  <= (w == 0) ? NUM_THREADS'(1) : '0;
        active_q <= (w == 0);
      end else begin
        tmask_q  <= tmask_d;
        active_q <= active_d;
      end
    end

    assign active_warps[w]                            = active_q;
    assign thread_masks[w*NUM_THREADS +: NUM_THREADS] = tmask_q;
  end

  logic                   spawn_valid_q, spawn_valid_d;
  logic [NUM_WARPS-1:0]   spawn_wmask_q, spawn_wmask_d;
  logic [PC_W-1:0]        spawn_pc_q, spawn_pc_d;
  logic                   ipdom_push_q, ipdom_push_d;
  logic [NW_W-1:0]        ipdom_wid_q, ipdom_wid_d;
  logic [NUM_THREADS-1:0] ipdom_tmask_q, ipdom_tmask_d;
  logic [PC_W-1:0]        ipdom_pc_q, ipdom_pc_d;

  always_comb begin
    spawn_valid_d = wspawn_fire;
    spawn_wmask_d = spawn_mask;
    spawn_pc_d    = wspawn_fire ? wspawn_pc : '0;
    ipdom_push_d  = split_fire;
    ipdom_wid_d   = split_fire ? wid : '0;
    ipdom_tmask_d = split_fire ? split_else_tmask : '0;
    ipdom_pc_d    = split_fire ? split_pc : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spawn_valid_q <= 1'b0;
      spawn_wmask_q <= '0;
      spawn_pc_q    <= '0;
      ipdom_push_q  <= 1'b0;
      ipdom_wid_q   <= '0;
      ipdom_tmask_q <= '0;
      ipdom_pc_q    <= '0;
    end else begin
      spawn_valid_q <= spawn_valid_d;
      spawn_wmask_q <= spawn_wmask_d;
      spawn_pc_q    <= spawn_pc_d;
      ipdom_push_q  <= ipdom_push_d;
      ipdom_wid_q   <= ipdom_wid_d;
      ipdom_tmask_q <= ipdom_tmask_d;
      ipdom_pc_q    <= ipdom_pc_d;
    end
  end

  assign spawn_valid = spawn_valid_q;
  assign spawn_wmask = spawn_wmask_q;
  assign spawn_pc    = spawn_pc_q;
  assign ipdom_push  = ipdom_push_q;
  assign ipdom_wid   = ipdom_wid_q;
  assign ipdom_tmask = ipdom_tmask_q;
  assign ipdom_pc    = ipdom_pc_q;

`ifdef VX_WCTL_BARRIER_EN
  logic [NW_W-1:0]      count_q [NUM_BARRIERS];
  logic [NW_W-1:0]      count_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] bmask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] bmask_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic                 rel_q, rel_d;
  logic [NB_W-1:0]      rel_id_q, rel_id_d;

  // A repeat arrival from a warp already waiting is dropped before the count compare.
  always_comb begin
    count_d   = count_q;
    bmask_d   = bmask_q;
    stalled_d = stalled_q;
    rel_d     = 1'b0;
    rel_id_d  = '0;
    if (valid && bar_valid && !bmask_q[bar_id][wid]) begin
      if (count_q[bar_id] == bar_size_m1) begin
        stalled_d       = stalled_q & ~(bmask_q[bar_id] | wid_oh);
        count_d[bar_id] = '0;
        bmask_d[bar_id] = '0;
        rel_d           = 1'b1;
        rel_id_d        = bar_id;
      end else begin
        count_d[bar_id] = count_q[bar_id] + NW_W'(1);
        bmask_d[bar_id] = bmask_q[bar_id] | wid_oh;
        stalled_d       = stalled_q | wid_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '{default: '0};
      bmask_q   <= '{default: '0};
      stalled_q <= '0;
      rel_q     <= 1'b0;
      rel_id_q  <= '0;
    end else begin
      count_q   <= count_d;
      bmask_q   <= bmask_d;
      stalled_q <= stalled_d;
      rel_q     <= rel_d;
      rel_id_q  <= rel_id_d;
    end
  end

  assign stalled_warps  = stalled_q;
  assign bar_release    = rel_q;
  assign bar_release_id = rel_id_q;
`else
  logic bar_unused;
  assign bar_unused     = ^{bar_valid, bar_id, bar_size_m1};
  assign stalled_warps  = '0;
  assign bar_release    = 1'b0;
  assign bar_release_id = '0;
`endif

endmodule

// File: tb/tb_vx_warp_ctl_handler.sv
// Self-checking bench for vx_warp_ctl_handler: directed scenarios plus randomized traffic
// checked against a membership-set reference model.
module tb_vx_warp_ctl_handler;
  localparam int NW  = 4;
  localparam int NT  = 4;
  localparam int NB  = 4;
  localparam int PCW = 32;
`ifdef VX_WCTL_BARRIER_EN
  localparam bit BAR_EN = 1'b1;
`else
  localparam bit BAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, valid;
  logic [1:0]     wid;
  logic           tmc_valid;
  logic [NT-1:0]  tmc_tmask;
  logic           wspawn_valid;
  logic [NW-1:0]  wspawn_wmask;
  logic [PCW-1:0] wspawn_pc;
  logic           bar_valid;
  logic [1:0]     bar_id, bar_size_m1;
  logic           split_valid, split_diverged;
  logic [NT-1:0]  split_then_tmask, split_else_tmask;
  logic [PCW-1:0] split_pc;
  logic [NW-1:0]  active_warps, stalled_warps;
  logic [NW*NT-1:0] thread_masks;
  logic           spawn_valid;
  logic [NW-1:0]  spawn_wmask;
  logic [PCW-1:0] spawn_pc;
  logic           bar_release;
  logic [1:0]     bar_release_id;
  logic           ipdom_push;
  logic [1:0]     ipdom_wid;
  logic [NT-1:0]  ipdom_tmask;
  logic [PCW-1:0] ipdom_pc;

  vx_warp_ctl_handler #(.NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_BARRIERS(NB), .PC_W(PCW)) dut (
    .clk(clk), .reset(reset), .valid(valid), .wid(wid),
    .tmc_valid(tmc_valid), .tmc_tmask(tmc_tmask),
    .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
    .bar_valid(bar_valid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
    .split_valid(split_valid), .split_diverged(split_diverged),
    .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask), .split_pc(split_pc),
    .active_warps(active_warps), .stalled_warps(stalled_warps), .thread_masks(thread_masks),
    .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
    .bar_release(bar_release), .bar_release_id(bar_release_id),
    .ipdom_push(ipdom_push), .ipdom_wid(ipdom_wid), .ipdom_tmask(ipdom_tmask), .ipdom_pc(ipdom_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-warp state and, per barrier, the set of waiting warps.
  logic [NW-1:0]  m_active, m_stalled;
  logic [NT-1:0]  m_tmask   [NW];
  logic [NW-1:0]  m_members [NB];
  logic           e_spawn_valid, e_rel, e_push;
  logic [NW-1:0]  e_spawn_wmask;
  logic [PCW-1:0] e_spawn_pc, e_push_pc;
  logic [1:0]     e_rel_id, e_push_wid;
  logic [NT-1:0]  e_push_tmask;

  task automatic model_reset();
    m_active  = 4'b0001;
    m_stalled = '0;
    for (int w = 0; w < NW; w++) m_tmask[w] = (w == 0) ? 4'b0001 : 4'b0000;
    for (int b = 0; b < NB; b++) m_members[b] = '0;
  endtask

  task automatic model_step();
    e_spawn_valid = 1'b0; e_spawn_wmask = '0; e_spawn_pc = '0;
    e_rel = 1'b0; e_rel_id = '0;
    e_push = 1'b0; e_push_wid = '0; e_push_tmask = '0; e_push_pc = '0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!valid) return;
    if (wspawn_valid) begin
      e_spawn_valid = 1'b1;
      e_spawn_pc    = wspawn_pc;
      e_spawn_wmask = wspawn_wmask;
      e_spawn_wmask[wid] = 1'b0;
      for (int w = 0; w < NW; w++)
        if (e_spawn_wmask[w]) begin
          m_active[w] = 1'b1;
          m_tmask[w]  = 4'b0001;
        end
    end
    if (split_valid && split_diverged) begin
      m_tmask[wid] = split_then_tmask;
      e_push = 1'b1; e_push_wid = wid; e_push_tmask = split_else_tmask; e_push_pc = split_pc;
    end
    if (tmc_valid) begin
      m_tmask[wid]  = tmc_tmask;
      m_active[wid] = (tmc_tmask != 0);
    end
    if (BAR_EN && bar_valid && !m_members[bar_id][wid]) begin
      if ($countones(m_members[bar_id]) == int'(bar_size_m1)) begin
        m_stalled = m_stalled & ~m_members[bar_id];
        m_stalled[wid] = 1'b0;
        m_members[bar_id] = '0;
        e_rel = 1'b1; e_rel_id = bar_id;
      end else begin
        m_members[bar_id][wid] = 1'b1;
        m_stalled[wid] = 1'b1;
      end
    end
  endtask

  function automatic logic [NW*NT-1:0] model_tmasks();
    logic [NW*NT-1:0] r;
    for (int w = 0; w < NW; w++) r[w*NT +: NT] = m_tmask[w];
    return r;
  endfunction

  task automatic idle();
    reset = 1'b0; valid = 1'b0; wid = '0;
    tmc_valid = 1'b0; tmc_tmask = '0;
    wspawn_valid = 1'b0; wspawn_wmask = '0; wspawn_pc = '0;
    bar_valid = 1'b0; bar_id = '0; bar_size_m1 = '0;
    split_valid = 1'b0; split_diverged = 1'b0; split_then_tmask = '0; split_else_tmask = '0; split_pc = '0;
  endtask

  task automatic drive_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    drive_cycle();
    drive_cycle();
    reset = 1'b0;
    drive_cycle();
    n_checks++; if (active_warps !== 4'b0001) begin n_fail++; $display("FAIL reset_active got=%b exp=0001", active_warps); end
    n_checks++; if (thread_masks !== 16'h0001) begin n_fail++; $display("FAIL reset_tmasks got=%h exp=0001", thread_masks); end
    n_checks++; if (stalled_warps !== 4'b0000) begin n_fail++; $display("FAIL reset_stalled got=%b exp=0000", stalled_warps); end
    n_checks++; if ({spawn_valid, bar_release, ipdom_push} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {spawn_valid, bar_release, ipdom_push}); end
  endtask

  task automatic test_wspawn();
    idle();
    valid = 1'b1; wid = 2'd0; wspawn_valid = 1'b1; wspawn_wmask = 4'b1111; wspawn_pc = 32'h8000_0100;
    drive_cycle();
    n_checks++; if (active_warps !== 4'b1111) begin n_fail++; $display("FAIL spawn_active got=%b exp=1111", active_warps); end
    n_checks++; if (spawn_valid !== 1'b1) begin n_fail++; $display("FAIL spawn_valid got=%b exp=1", spawn_valid); end
    n_checks++; if (spawn_wmask !== 4'b1110) begin n_fail++; $display("FAIL spawn_wmask got=%b exp=1110", spawn_wmask); end
    n_checks++; if (spawn_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL spawn_pc got=%h exp=80000100", spawn_pc); end
    n_checks++; if (thread_masks !== 16'h1111) begin n_fail++; $display("FAIL spawn_tmasks got=%h exp=1111", thread_masks); end
    idle();
    drive_cycle();
    n_checks++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL spawn_pulse_len got=%b exp=0", spawn_valid); end
  endtask

  task automatic test_tmc();
    idle();
    valid = 1'b1; wid = 2'd2; tmc_valid = 1'b1; tmc_tmask = 4'b0000;
    drive_cycle();
    n_checks++; if (active_warps !== 4'b1011) begin n_fail++; $display("FAIL tmc_off_active got=%b exp=1011", active_warps); end
    n_checks++; if (thread_masks[11:8] !== 4'b0000) begin n_fail++; $display("FAIL tmc_off_tmask got=%b exp=0000", thread_masks[11:8]); end
    tmc_tmask = 4'b0101;
    drive_cycle();
    n_checks++; if (active_warps !== 4'b1111) begin n_fail++; $display("FAIL tmc_on_active got=%b exp=1111", active_warps); end
    n_checks++; if (thread_masks[11:8] !== 4'b0101) begin n_fail++; $display("FAIL tmc_on_tmask got=%b exp=0101", thread_masks[11:8]); end
  endtask

  task automatic test_split();
    idle();
    valid = 1'b1; wid = 2'd1; split_valid = 1'b1; split_diverged = 1'b1;
    split_then_tmask = 4'b0011; split_else_tmask = 4'b1100; split_pc = 32'h100;
    drive_cycle();
    n_checks++; if (thread_masks[7:4] !== 4'b0011) begin n_fail++; $display("FAIL split_tmask got=%b exp=0011", thread_masks[7:4]); end
    n_checks++; if ({ipdom_push, ipdom_wid, ipdom_tmask} !== {1'b1, 2'd1, 4'b1100}) begin n_fail++; $display("FAIL split_push got=%b/%0d/%b exp=1/1/1100", ipdom_push, ipdom_wid, ipdom_tmask); end
    n_checks++; if (ipdom_pc !== 32'h100) begin n_fail++; $display("FAIL split_pc got=%h exp=00000100", ipdom_pc); end
    split_diverged = 1'b0; split_then_tmask = 4'b1111;
    drive_cycle();
    n_checks++; if (ipdom_push !== 1'b0) begin n_fail++; $display("FAIL nodiv_push got=%b exp=0", ipdom_push); end
    n_checks++; if (thread_masks[7:4] !== 4'b0011) begin n_fail++; $display("FAIL nodiv_tmask got=%b exp=0011", thread_masks[7:4]); end
  endtask

  task automatic test_tmc_split_same();
    idle();
    valid = 1'b1; wid = 2'd3; tmc_valid = 1'b1; tmc_tmask = 4'b1010;
    split_valid = 1'b1; split_diverged = 1'b1; split_then_tmask = 4'b0110; split_else_tmask = 4'b1001; split_pc = 32'h200;
    drive_cycle();
    n_checks++; if (thread_masks[15:12] !== 4'b1010) begin n_fail++; $display("FAIL tmcsplit_tmask got=%b exp=1010", thread_masks[15:12]); end
    n_checks++; if ({ipdom_push, ipdom_wid, ipdom_tmask} !== {1'b1, 2'd3, 4'b1001}) begin n_fail++; $display("FAIL tmcsplit_push got=%b/%0d/%b exp=1/3/1001", ipdom_push, ipdom_wid, ipdom_tmask); end
  endtask

  task automatic test_barrier();
    logic [1:0] seq_wid [4];
    logic [3:0] seq_stall [4];
    seq_wid = '{2'd1, 2'd1, 2'd3, 2'd0};
    seq_stall = '{4'b0010, 4'b0010, 4'b1010, 4'b0000};
    idle();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; bar_valid = 1'b1; bar_id = 2'd2; bar_size_m1 = 2'd2; wid = seq_wid[i];
      drive_cycle();
      n_checks++; if (stalled_warps !== (BAR_EN ? seq_stall[i] : 4'b0000)) begin n_fail++; $display("FAIL bar_stall[%0d] got=%b exp=%b", i, stalled_warps, BAR_EN ? seq_stall[i] : 4'b0000); end
      n_checks++; if (bar_release !== (BAR_EN && i == 3)) begin n_fail++; $display("FAIL bar_rel[%0d] got=%b exp=%b", i, bar_release, BAR_EN && i == 3); end
    end
    n_checks++; if (bar_release_id !== (BAR_EN ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL bar_rel_id got=%0d exp=%0d", bar_release_id, BAR_EN ? 2 : 0); end
    idle();
    drive_cycle();
    n_checks++; if (bar_release !== 1'b0) begin n_fail++; $display("FAIL bar_rel_len got=%b exp=0", bar_release); end
    valid = 1'b1; bar_valid = 1'b1; bar_id = 2'd1; bar_size_m1 = 2'd0; wid = 2'd2;
    drive_cycle();
    n_checks++; if ({bar_release, stalled_warps} !== {BAR_EN, 4'b0000}) begin n_fail++; $display("FAIL bar_imm got=%b/%b exp=%b/0000", bar_release, stalled_warps, BAR_EN); end
  endtask

  task automatic test_reset_mid_barrier();
    idle();
    valid = 1'b1; bar_valid = 1'b1; bar_id = 2'd0; bar_size_m1 = 2'd3; wid = 2'd1;
    drive_cycle();
    n_checks++; if (stalled_warps !== (BAR_EN ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL midrst_pre got=%b exp=%b", stalled_warps, BAR_EN ? 4'b0010 : 4'b0000); end
    reset = 1'b1; bar_size_m1 = 2'd1; wid = 2'd2;
    drive_cycle();
    n_checks++; if ({bar_release, stalled_warps, active_warps} !== {1'b0, 4'b0000, 4'b0001}) begin n_fail++; $display("FAIL midrst_clear got=%b/%b/%b exp=0/0000/0001", bar_release, stalled_warps, active_warps); end
    reset = 1'b0;
    drive_cycle();
    n_checks++; if ({bar_release, stalled_warps} !== {1'b0, BAR_EN ? 4'b0100 : 4'b0000}) begin n_fail++; $display("FAIL midrst_fresh got=%b/%b exp=0/%b", bar_release, stalled_warps, BAR_EN ? 4'b0100 : 4'b0000); end
    wid = 2'd3;
    drive_cycle();
    n_checks++; if ({bar_release, stalled_warps} !== {BAR_EN, 4'b0000}) begin n_fail++; $display("FAIL midrst_rel got=%b/%b exp=%b/0000", bar_release, stalled_warps, BAR_EN); end
  endtask

  task automatic test_random();
    logic [1:0] bar_sz [NB];
    for (int b = 0; b < NB; b++) bar_sz[b] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 600; i++) begin
      reset            = ($urandom_range(0, 99) < 2);
      valid            = ($urandom_range(0, 9) < 8);
      wid              = 2'($urandom);
      tmc_valid        = ($urandom_range(0, 3) == 0);
      tmc_tmask        = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      wspawn_valid     = ($urandom_range(0, 7) == 0);
      wspawn_wmask     = 4'($urandom);
      wspawn_pc        = $urandom;
      bar_valid        = ($urandom_range(0, 2) == 0);
      bar_id           = 2'($urandom);
      bar_size_m1      = bar_sz[bar_id];
      split_valid      = ($urandom_range(0, 3) == 0);
      split_diverged   = 1'($urandom);
      split_then_tmask = 4'($urandom);
      split_else_tmask = 4'($urandom);
      split_pc         = $urandom;
      drive_cycle();
      n_checks++; if (active_warps !== m_active) begin n_fail++; $display("FAIL rnd_active[%0d] got=%b exp=%b", i, active_warps, m_active); end
      n_checks++; if (thread_masks !== model_tmasks()) begin n_fail++; $display("FAIL rnd_tmasks[%0d] got=%h exp=%h", i, thread_masks, model_tmasks()); end
      n_checks++; if (stalled_warps !== m_stalled) begin n_fail++; $display("FAIL rnd_stalled[%0d] got=%b exp=%b", i, stalled_warps, m_stalled); end
      n_checks++; if (spawn_valid !== e_spawn_valid) begin n_fail++; $display("FAIL rnd_spawn[%0d] got=%b exp=%b", i, spawn_valid, e_spawn_valid); end
      if (e_spawn_valid) begin
        n_checks++; if ({spawn_wmask, spawn_pc} !== {e_spawn_wmask, e_spawn_pc}) begin n_fail++; $display("FAIL rnd_spawn_data[%0d] got=%b/%h exp=%b/%h", i, spawn_wmask, spawn_pc, e_spawn_wmask, e_spawn_pc); end
      end
      n_checks++; if (bar_release !== e_rel) begin n_fail++; $display("FAIL rnd_rel[%0d] got=%b exp=%b", i, bar_release, e_rel); end
      if (e_rel) begin
        n_checks++; if (bar_release_id !== e_rel_id) begin n_fail++; $display("FAIL rnd_rel_id[%0d] got=%0d exp=%0d", i, bar_release_id, e_rel_id); end
      end
      n_checks++; if (ipdom_push !== e_push) begin n_fail++; $display("FAIL rnd_push[%0d] got=%b exp=%b", i, ipdom_push, e_push); end
      if (e_push) begin
        n_checks++; if ({ipdom_wid, ipdom_tmask, ipdom_pc} !== {e_push_wid, e_push_tmask, e_push_pc}) begin n_fail++; $display("FAIL rnd_push_data[%0d] got=%0d/%b/%h exp=%0d/%b/%h", i, ipdom_wid, ipdom_tmask, ipdom_pc, e_push_wid, e_push_tmask, e_push_pc); end
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_wspawn();
    test_tmc();
    test_split();
    test_tmc_split_same();
    test_barrier();
    test_reset_mid_barrier();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
